bcd_serial_adder: RTL

Digit-serial multi-digit BCD adder controller that sits directly upstream of the single-digit bcd_adder stage. It feeds bcd_adder one digit pair per clock, least-significant digit first, and carries Cout into the next Cin. It collects the sum digits into a packed DIGITS-wide BCD result. Valid/ready handshakes are used on both the operand side and the result side.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_adder.sv | 27 ++
 rtl/bcd_serial_adder.sv | 110 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the digit-serial BCD adder.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [4:0]  BCD_CORR = 5'd6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/bcd_adder.sv
// Combinational single-digit BCD adder: decimal-corrected sum of two digits plus carry.
module bcd_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] A,
  input  logic [DIGIT_W-1:0] B,
  input  logic               Cin,
  output logic [DIGIT_W-1:0] Sum,
  output logic               Cout
);

  logic [4:0] t;
  logic [4:0] t_corr;

  always_comb begin
    t      = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
    t_corr = t + BCD_CORR;
    if (t > {1'b0, BCD_MAX}) begin
      Sum  = t_corr[3:0];
      Cout = 1'b1;
    end else begin
      Sum  = t[3:0];
      Cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, LSD first, with valid/ready on both sides.
// Optional invalid-digit flag enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e                state_q;
  logic [4*DIGITS-1:0]   a_q, b_q, sum_q;
  logic [IdxW-1:0]       idx_q;
  logic                  carry_q, cout_q, err_q;

  logic [DIGIT_W-1:0]    a_dig, b_dig, add_sum;
  logic                  add_cout;
  logic                  bad_digit;

  always_comb begin
    a_dig = a_q[DIGIT_W*idx_q +: DIGIT_W];
    b_dig = b_q[DIGIT_W*idx_q +: DIGIT_W];
  end

  bcd_adder u_bcd_adder (
    .A    (a_dig),
    .B    (b_dig),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

`ifdef BCD_DIGIT_CHECK_EN
  // Flag evaluated on the raw operands so it is ready at the acceptance edge.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[DIGIT_W*i +: DIGIT_W] > BCD_MAX || b[DIGIT_W*i +: DIGIT_W] > BCD_MAX) begin
        bad_digit = 1'b1;
      end
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= bad_digit;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[DIGIT_W*idx_q +: DIGIT_W] <= add_sum;
          carry_q <= add_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IdxW'(DIGITS - 1)) begin
            cout_q  <= add_cout;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule
